pf_i2c_master_ctrl: RTL and testbench

//  Byte-level I2C master sequencer driving two open-drain PF_IO wrappers (SDA, SCL) through their D/E/Y pins.

---
 rtl/pf_i2c_master_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_pf_i2c_master_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_i2c_master_ctrl.sv
// pf_i2c_master_ctrl
//  Byte-level I2C master sequencer for two open-drain PF_IO pads (SDA, SCL).
//  Runs START / WRITE / READ / STOP commands from a valid/ready port and
//  returns ACK status and read data with a one-cycle response pulse.
//
//  Parameter
//    CLK_DIV      clk cycles per SCL quarter period (2..65535)
//  Ports
//    clk_i, reset_i           clock, synchronous active-high reset
//    cmd_valid_i/cmd_ready_o  command handshake
//    cmd_i[2:0]               000 START, 001 WRITE, 010 READ, 011 STOP, 1xx illegal
//    cmd_ack_i                READ: 1 = master ACKs the byte, 0 = NACK
//    wdata_i[7:0]             WRITE byte, sent MSB first
//    rdata_o[7:0]             READ result, valid with rsp_valid_o
//    rsp_valid_o              one-cycle completion pulse
//    rsp_nack_o               WRITE: slave did not acknowledge
//    rsp_err_o                illegal command code
//    busy_o                   bus owned (START done .. STOP done)
//    sda_d_o/scl_d_o          pad data, tied low (open drain)
//    sda_e_o/scl_e_o          1 = pull pad low, 0 = release
//    sda_y_i/scl_y_i          pad inputs
//  Build option
//    I2C_CLK_STRETCH_EN       when defined, the quarter counter holds in Q1/Q2
//                             while scl_y_i is low (slave clock stretching)

module pf_i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_i,
    input  logic       cmd_ack_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       rsp_valid_o,
    output logic       rsp_nack_o,
    output logic       rsp_err_o,
    output logic       busy_o,
    output logic       sda_d_o,
    output logic       sda_e_o,
    input  logic       sda_y_i,
    output logic       scl_d_o,
    output logic       scl_e_o,
    input  logic       scl_y_i
);

    localparam int unsigned QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

    localparam logic [2:0] CMD_START = 3'b000;
    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_STOP  = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]  quar_q, quar_d;
    logic [3:0]  bit_q, bit_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic [7:0]  shift_q, shift_d;
    logic        nack_q, nack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_nack_q, rsp_nack_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;
    logic        sda_e_q, sda_e_d;
    logic        scl_e_q, scl_e_d;
    logic        hold_c;
    logic        tick_c;

    // SDA pull-down for data bit idx (0..7 data, 8 = acknowledge slot)
    function automatic logic bit_sda(input logic [2:0] cmd, input logic [7:0] wdata,
                                     input logic ack, input logic [3:0] idx);
        logic v;
        v = 1'b0;
        if (idx < 4'd8) begin
            if (cmd == CMD_WRITE) v = ~wdata[3'(4'd7 - idx)];
        end else if (cmd == CMD_READ) begin
            v = ack;
        end
        return v;
    endfunction

`ifdef I2C_CLK_STRETCH_EN
    // Slave holding SCL low freezes the high phase
    assign hold_c = (state_q == S_START || state_q == S_BIT || state_q == S_STOP) &&
                    (quar_q == 2'd1 || quar_q == 2'd2) && !scl_y_i;
`else
    logic scl_y_unused;
    assign scl_y_unused = scl_y_i;
    assign hold_c       = 1'b0;
`endif

    assign tick_c = (qcnt_q == QMAX) && !hold_c;

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            qcnt_q      <= '0;
            quar_q      <= 2'd0;
            bit_q       <= 4'd0;
            cmd_q       <= 3'd0;
            wdata_q     <= 8'h00;
            ack_q       <= 1'b0;
            shift_q     <= 8'h00;
            nack_q      <= 1'b0;
            rdata_q     <= 8'h00;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_nack_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            sda_e_q     <= 1'b0;
            scl_e_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            quar_q      <= quar_d;
            bit_q       <= bit_d;
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            shift_q     <= shift_d;
            nack_q      <= nack_d;
            rdata_q     <= rdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_nack_q  <= rsp_nack_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            sda_e_q     <= sda_e_d;
            scl_e_q     <= scl_e_d;
        end
    end

    // Next state; pad enables are set for the quarter being entered
    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        quar_d      = quar_q;
        bit_d       = bit_q;
        cmd_d       = cmd_q;
        wdata_d     = wdata_q;
        ack_d       = ack_q;
        shift_d     = shift_q;
        nack_d      = nack_q;
        rdata_d     = rdata_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_nack_d  = 1'b0;
        rsp_err_d   = 1'b0;
        busy_d      = busy_q;
        sda_e_d     = sda_e_q;
        scl_e_d     = scl_e_q;

        if ((state_q == S_START || state_q == S_BIT || state_q == S_STOP) && !hold_c) begin
            qcnt_d = tick_c ? '0 : qcnt_q + QW'(1);
            if (tick_c) quar_d = quar_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_d       = cmd_i;
                    wdata_d     = wdata_i;
                    ack_d       = cmd_ack_i;
                    cmd_ready_d = 1'b0;
                    qcnt_d      = '0;
                    quar_d      = 2'd0;
                    bit_d       = 4'd0;
                    case (cmd_i)
                        CMD_START: begin
                            state_d = S_START;
                            sda_e_d = 1'b0;
                        end
                        CMD_WRITE, CMD_READ: begin
                            state_d = S_BIT;
                            scl_e_d = 1'b1;
                            sda_e_d = bit_sda(cmd_i, wdata_i, cmd_ack_i, 4'd0);
                        end
                        CMD_STOP: begin
                            state_d = S_STOP;
                            sda_e_d = 1'b1;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_START: begin
                if (tick_c) begin
                    case (quar_q)
                        2'd0: scl_e_d = 1'b0;
                        2'd1: sda_e_d = 1'b1;
                        2'd2: scl_e_d = 1'b1;
                        default: begin
                            state_d = S_DONE;
                            busy_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_BIT: begin
                if (tick_c) begin
                    case (quar_q)
                        2'd0: scl_e_d = 1'b0;
                        2'd1: ;
                        2'd2: begin
                            scl_e_d = 1'b1;
                            if (bit_q < 4'd8) shift_d = {shift_q[6:0], sda_y_i};
                            else nack_d = sda_y_i;
                        end
                        default: begin
                            if (bit_q == 4'd8) begin
                                state_d = S_DONE;
                            end else begin
                                bit_d   = bit_q + 4'd1;
                                sda_e_d = bit_sda(cmd_q, wdata_q, ack_q, bit_q + 4'd1);
                            end
                        end
                    endcase
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    case (quar_q)
                        2'd0: scl_e_d = 1'b0;
                        2'd1: sda_e_d = 1'b0;
                        2'd2: ;
                        default: begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                cmd_ready_d = 1'b1;
                rsp_nack_d  = (cmd_q == CMD_WRITE) && nack_q;
                rsp_err_d   = cmd_q[2];
                if (cmd_q == CMD_READ) rdata_d = shift_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rdata_o     = rdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_nack_o  = rsp_nack_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign sda_e_o     = sda_e_q;
    assign scl_e_o     = scl_e_q;
    assign sda_d_o     = 1'b0;
    assign scl_d_o     = 1'b0;

endmodule

// File: tb/tb_pf_i2c_master_ctrl.sv
// Bench for pf_i2c_master_ctrl with CLK_DIV=4 (quarter 4, bit 16, byte 144 cycles).
// Pads are modelled as open-drain wires with a cycle-timed slave model.
module tb_pf_i2c_master_ctrl;

    localparam int unsigned D   = 4;
    localparam int unsigned BIT = 4 * D;

    localparam logic [2:0] C_START = 3'b000;
    localparam logic [2:0] C_WRITE = 3'b001;
    localparam logic [2:0] C_READ  = 3'b010;
    localparam logic [2:0] C_STOP  = 3'b011;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic       cmd_ack;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rsp_valid, rsp_nack, rsp_err, busy;
    logic       sda_d, sda_e, sda_y, scl_d, scl_e, scl_y;
    logic       slave_pull, stretch_pull;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sda_y = ~(sda_e | slave_pull);
    assign scl_y = ~(scl_e | stretch_pull);

    pf_i2c_master_ctrl #(.CLK_DIV(D)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_i(cmd), .cmd_ack_i(cmd_ack), .wdata_i(wdata),
        .rdata_o(rdata), .rsp_valid_o(rsp_valid), .rsp_nack_o(rsp_nack),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .sda_d_o(sda_d), .sda_e_o(sda_e), .sda_y_i(sda_y),
        .scl_d_o(scl_d), .scl_e_o(scl_e), .scl_y_i(scl_y)
    );

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] wdata;
        logic       cmd_ack;
        logic [7:0] slave_byte;
        logic       slave_ack;
        int         exp_lat;
        logic       exp_nack;
        logic       exp_err;
        logic [7:0] exp_rdata;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: transaction-level expectations
    function automatic int model_lat(input logic [2:0] c);
        if (c[2]) return 1;
        if (c == C_WRITE || c == C_READ) return 36 * D + 1;
        return 4 * D + 1;
    endfunction

    // Master SDA pull-downs sampled in Q2 of bits 1..9 (bit 1 in [8])
    function automatic logic [8:0] model_bits(input logic [2:0] c, input logic [7:0] wd,
                                              input logic ack);
        if (c == C_WRITE) return {~wd, 1'b0};
        return {8'h00, ack};
    endfunction

    // Issue one command, play the slave, measure latency from the accept edge
    task automatic run_cmd(input logic [2:0] c, input logic [7:0] wd, input logic ack,
                           input logic [7:0] sbyte, input logic sack, input int stretch_at,
                           output int lat, output logic [8:0] bits, output logic scl_ok,
                           output logic sda_q1, output logic ready_after);
        int cyc;
        int k;
        int r;
        cmd       = c;
        wdata     = wd;
        cmd_ack   = ack;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        ready_after = cmd_ready;
        bits   = '0;
        scl_ok = 1'b1;
        sda_q1 = 1'b0;
        cyc    = 0;
        lat    = -1;
        while (cyc < 2000) begin
            k = cyc / BIT;
            r = cyc % BIT;
            if (c == C_READ && k < 8) slave_pull = ~sbyte[7-k];
            else if (c == C_WRITE && k == 8) slave_pull = sack;
            else slave_pull = 1'b0;
            stretch_pull = (stretch_at >= 0) && (cyc >= stretch_at) && (cyc < stretch_at + 20);
            if (r == 2 * D + 1 && k < 9) begin
                bits[8-k] = sda_e;
                if (scl_e) scl_ok = 1'b0;
            end
            if (r == D + 1 && k == 0) sda_q1 = sda_e;
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid) begin
                lat = cyc;
                break;
            end
        end
        slave_pull   = 1'b0;
        stretch_pull = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag, input logic chk_bits);
        int lat;
        logic [8:0] bits;
        logic scl_ok, sda_q1, ready_after;
        run_cmd(v.cmd, v.wdata, v.cmd_ack, v.slave_byte, v.slave_ack, -1,
                lat, bits, scl_ok, sda_q1, ready_after);
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " ready low after accept"}, 32'(ready_after), 32'(0));
        if (lat > 0) begin
            check({tag, " rsp_nack"}, 32'(rsp_nack), 32'(v.exp_nack));
            check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
            check({tag, " ready with rsp"}, 32'(cmd_ready), 32'(1));
            check({tag, " busy"}, 32'(busy), 32'(v.exp_busy));
            if (v.cmd == C_READ) check({tag, " rdata"}, 32'(rdata), 32'(v.exp_rdata));
            if (chk_bits && (v.cmd == C_WRITE || v.cmd == C_READ)) begin
                check({tag, " sda bits"}, 32'(bits), 32'(model_bits(v.cmd, v.wdata, v.cmd_ack)));
                check({tag, " scl high in Q2"}, 32'(scl_ok), 32'(1));
            end
            if (v.cmd == C_START) begin
                check({tag, " start Q2 sda low"}, 32'(bits[8]), 32'(1));
                check({tag, " start Q2 scl high"}, 32'(scl_ok), 32'(1));
            end
            if (v.cmd == C_STOP) begin
                check({tag, " stop Q1 sda low"}, 32'(sda_q1), 32'(1));
                check({tag, " stop Q2 sda released"}, 32'(bits[8]), 32'(0));
                check({tag, " stop Q2 scl high"}, 32'(scl_ok), 32'(1));
            end
            @(posedge clk); #1;
            check({tag, " rsp one cycle"}, 32'(rsp_valid), 32'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int lat;
        logic [8:0] bits;
        logic scl_ok, sda_q1, ready_after;
        logic seen;

        vecs[0] = '{C_START,  8'h00, 1'b0, 8'h00, 1'b0, 17,  1'b0, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{C_WRITE,  8'hA5, 1'b0, 8'h00, 1'b1, 145, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{C_WRITE,  8'h3C, 1'b0, 8'h00, 1'b0, 145, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{C_READ,   8'h00, 1'b0, 8'h5A, 1'b0, 145, 1'b0, 1'b0, 8'h5A, 1'b1};
        vecs[4] = '{C_READ,   8'h00, 1'b1, 8'hC3, 1'b0, 145, 1'b0, 1'b0, 8'hC3, 1'b1};
        vecs[5] = '{C_STOP,   8'h00, 1'b0, 8'h00, 1'b0, 17,  1'b0, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{3'b101,   8'h00, 1'b0, 8'h00, 1'b0, 1,   1'b0, 1'b1, 8'h00, 1'b0};
        vecs[7] = '{3'b111,   8'h00, 1'b0, 8'h00, 1'b0, 1,   1'b0, 1'b1, 8'h00, 1'b0};

        reset = 1'b1; cmd_valid = 1'b1; cmd = C_START; cmd_ack = 1'b0; wdata = 8'h00;
        slave_pull = 1'b0; stretch_pull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset sda_e", 32'(sda_e), 32'(0));
        check("reset scl_e", 32'(scl_e), 32'(0));
        check("reset cmd_ready", 32'(cmd_ready), 32'(1));
        check("reset rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset rdata", 32'(rdata), 32'(0));
        check("pad data tied low", 32'({sda_d, scl_d}), 32'(0));
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("vec%0d", i), 1'b1);

        // Randomised WRITE/READ traffic inside one START..STOP frame
        v = '{C_START, 8'h00, 1'b0, 8'h00, 1'b0, model_lat(C_START), 1'b0, 1'b0, 8'h00, 1'b1};
        apply(v, "rnd start", 1'b1);
        for (int i = 0; i < 12; i++) begin
            v.cmd        = ($urandom_range(0, 1) == 0) ? C_WRITE : C_READ;
            v.wdata      = 8'($urandom);
            v.cmd_ack    = 1'($urandom);
            v.slave_byte = 8'($urandom);
            v.slave_ack  = 1'($urandom);
            v.exp_lat    = model_lat(v.cmd);
            v.exp_nack   = (v.cmd == C_WRITE) ? ~v.slave_ack : 1'b0;
            v.exp_err    = 1'b0;
            v.exp_rdata  = v.slave_byte;
            v.exp_busy   = 1'b1;
            apply(v, $sformatf("rnd%0d", i), 1'b1);
        end
        v = '{C_STOP, 8'h00, 1'b0, 8'h00, 1'b0, model_lat(C_STOP), 1'b0, 1'b0, 8'h00, 1'b0};
        apply(v, "rnd stop", 1'b1);

        // Slave stretches SCL for 20 cycles starting in Q1 of bit 3
        apply(vecs[0], "stretch start", 1'b1);
        run_cmd(C_WRITE, 8'h3C, 1'b0, 8'h00, 1'b0, 3 * BIT + D,
                lat, bits, scl_ok, sda_q1, ready_after);
`ifdef I2C_CLK_STRETCH_EN
        check("stretch latency", lat, 36 * D + 1 + 20);
`else
        check("stretch latency", lat, 36 * D + 1);
`endif
        check("stretch nack", 32'(rsp_nack), 32'(1));
        @(posedge clk); #1;

        // Reset in the middle of bit 4 of a WRITE
        cmd = C_WRITE; wdata = 8'h96; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4 * BIT + D + 1) @(posedge clk);
        #1;
        check("pre-reset scl released", 32'(scl_e), 32'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset sda_e", 32'(sda_e), 32'(0));
        check("midreset scl_e", 32'(scl_e), 32'(0));
        check("midreset cmd_ready", 32'(cmd_ready), 32'(1));
        check("midreset busy", 32'(busy), 32'(0));
        seen = rsp_valid;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("midreset no rsp_valid", 32'(seen), 32'(0));

        // Illegal code after reset: immediate error response, pads untouched
        run_cmd(3'b101, 8'h00, 1'b0, 8'h00, 1'b0, -1, lat, bits, scl_ok, sda_q1, ready_after);
        check("illegal latency", lat, 1);
        check("illegal err", 32'(rsp_err), 32'(1));
        check("illegal pads idle", 32'({sda_e, scl_e}), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
